// File: rtl/dpb_port_arbiter.sv
// dpb_port_arbiter: arbitrates two requesters onto RAM port A, with an r0 bus lock for read-modify-write.
// Build option DPB_ARB_RR_EN selects round-robin contention; without it r0 always wins contention.
module dpb_port_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_req,
    input  logic        r1_req,
    input  logic        r0_we,
    input  logic        r1_we,
    input  logic [11:0] r0_addr,
    input  logic [11:0] r1_addr,
    input  logic [7:0]  r0_wdata,
    input  logic [7:0]  r1_wdata,
    input  logic        r0_lock,
    output logic        r0_ack,
    output logic        r1_ack,
    output logic        r0_rvalid,
    output logic        r1_rvalid,
    output logic [7:0]  rdata,
    output logic        ram_ce,
    output logic        ram_we,
    output logic [11:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_oce,
    input  logic [7:0]  ram_dout,
    output logic        busy
);
    // state    | meaning
    // ST_IDLE  | no access in flight; arbitrate and latch the winner's command
    // ST_ISSUE | RAM enabled for one cycle, winner acked
    // ST_WAIT  | read data on ram_dout, captured into rdata at cycle end
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        ram_ce_q, ram_ce_d;
    logic        ram_we_q, ram_we_d;
    logic [11:0] ram_addr_q, ram_addr_d;
    logic [7:0]  ram_din_q, ram_din_d;
    logic        r0_ack_q, r0_ack_d;
    logic        r1_ack_q, r1_ack_d;
    logic        r0_rvalid_q, r0_rvalid_d;
    logic        r1_rvalid_q, r1_rvalid_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        busy_q, busy_d;
    logic        gnt_valid;
    logic        gnt_sel;

    // last_q is the last-granted requester (0 = r0, 1 = r1); it doubles as the
    // owner of the access in flight, since it updates on every grant.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_sel   = 1'b0;
        if (r0_lock && !last_q) begin
            gnt_valid = r0_req;
            gnt_sel   = 1'b0;
        end else if (r0_req && r1_req) begin
            gnt_valid = 1'b1;
`ifdef DPB_ARB_RR_EN
            gnt_sel   = ~last_q;
`else
            gnt_sel   = 1'b0;
`endif
        end else begin
            gnt_valid = r0_req | r1_req;
            gnt_sel   = r1_req & ~r0_req;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        ram_ce_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        r0_ack_d    = 1'b0;
        r1_ack_d    = 1'b0;
        r0_rvalid_d = 1'b0;
        r1_rvalid_d = 1'b0;
        rdata_d     = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    state_d    = ST_ISSUE;
                    last_d     = gnt_sel;
                    ram_ce_d   = 1'b1;
                    ram_we_d   = gnt_sel ? r1_we    : r0_we;
                    ram_addr_d = gnt_sel ? r1_addr  : r0_addr;
                    ram_din_d  = gnt_sel ? r1_wdata : r0_wdata;
                    r0_ack_d   = ~gnt_sel;
                    r1_ack_d   = gnt_sel;
                end
            end
            ST_ISSUE: begin
                state_d = ram_we_q ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                rdata_d     = ram_dout;
                r0_rvalid_d = ~last_q;
                r1_rvalid_d = last_q;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            ram_ce_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= 12'h000;
            ram_din_q   <= 8'h00;
            r0_ack_q    <= 1'b0;
            r1_ack_q    <= 1'b0;
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;
            rdata_q     <= 8'h00;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            ram_ce_q    <= ram_ce_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            r0_ack_q    <= r0_ack_d;
            r1_ack_q    <= r1_ack_d;
            r0_rvalid_q <= r0_rvalid_d;
            r1_rvalid_q <= r1_rvalid_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign r0_ack    = r0_ack_q;
    assign r1_ack    = r1_ack_q;
    assign r0_rvalid = r0_rvalid_q;
    assign r1_rvalid = r1_rvalid_q;
    assign rdata     = rdata_q;
    assign ram_ce    = ram_ce_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign ram_oce   = 1'b1;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dpb_port_arbiter.sv
// Self-checking bench for dpb_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level model (arbitration rules, shadow memory, latencies).
`timescale 1ns/1ps
module tb_dpb_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r0_req = 1'b0, r1_req = 1'b0, r0_we = 1'b0, r1_we = 1'b0, r0_lock = 1'b0;
    logic [11:0] r0_addr = 12'h0, r1_addr = 12'h0;
    logic [7:0]  r0_wdata = 8'h0, r1_wdata = 8'h0;
    logic        r0_ack, r1_ack, r0_rvalid, r1_rvalid;
    logic [7:0]  rdata;
    logic        ram_ce, ram_we, ram_oce, busy;
    logic [11:0] ram_addr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;

    int checks = 0;
    int errors = 0;

`ifdef DPB_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    dpb_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r1_req(r1_req), .r0_we(r0_we), .r1_we(r1_we),
        .r0_addr(r0_addr), .r1_addr(r1_addr), .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
        .r0_lock(r0_lock), .r0_ack(r0_ack), .r1_ack(r1_ack),
        .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid), .rdata(rdata),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_oce(ram_oce), .ram_dout(ram_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input logic [11:0] a);
        return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h3C;
    endfunction

    // RAM port A, read data valid the cycle after the RAM samples
    logic [7:0] mem [0:4095];
    bit         mem_wr [0:4095];
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) begin
                mem[ram_addr]    <= ram_din;
                mem_wr[ram_addr] <= 1'b1;
            end
            ram_dout <= mem_wr[ram_addr] ? mem[ram_addr] : init_byte(ram_addr);
        end
    end

    // expected memory contents, maintained by the bench only
    logic [7:0] shadow [0:4095];
    bit         sh_wr [0:4095];
    function automatic logic [7:0] sh_read(input logic [11:0] a);
        return sh_wr[a] ? shadow[a] : init_byte(a);
    endfunction
    task automatic sh_write(input logic [11:0] a, input logic [7:0] d);
        shadow[a] = d;
        sh_wr[a]  = 1'b1;
    endtask

    always @(negedge clk) begin
        checks++;
        if ((r0_ack && r1_ack) || (r0_rvalid && r1_rvalid) || ((r0_ack || r1_ack) && (r0_rvalid || r1_rvalid))) begin
            errors++;
            $display("FAIL mon_overlap t=%0t ack=%b%b rvalid=%b%b required at most one pulse", $time, r0_ack, r1_ack, r0_rvalid, r1_rvalid);
        end
        checks++;
        if (ram_ce !== (r0_ack | r1_ack)) begin
            errors++;
            $display("FAIL mon_ce t=%0t ram_ce=%b required=%b", $time, ram_ce, r0_ack | r1_ack);
        end
        checks++;
        if (ram_oce !== 1'b1) begin
            errors++;
            $display("FAIL mon_oce t=%0t ram_oce=%b required=1", $time, ram_oce);
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; r0_req = 1'b0; r1_req = 1'b0; r0_lock = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int who, input bit we, input logic [11:0] a, input logic [7:0] d);
        if (who == 0) begin r0_req = 1'b1; r0_we = we; r0_addr = a; r0_wdata = d; end
        else          begin r1_req = 1'b1; r1_we = we; r1_addr = a; r1_wdata = d; end
    endtask

    // returns cycles until ack (-1 on timeout) and drops req on ack
    task automatic wait_ack(input int who, output int lat);
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if ((who == 0) ? r0_ack : r1_ack) begin
                lat = i;
                if (who == 0) r0_req = 1'b0; else r1_req = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_rv(input int who, output int lat);
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if ((who == 0) ? r0_rvalid : r1_rvalid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++;
        if ({r0_ack, r1_ack, r0_rvalid, r1_rvalid, ram_ce, ram_we, busy} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctl got=%b required=0000000", {r0_ack, r1_ack, r0_rvalid, r1_rvalid, ram_ce, ram_we, busy});
        end
        checks++;
        if ({ram_addr, ram_din, rdata} !== 28'h0) begin
            errors++;
            $display("FAIL reset_data addr=%h din=%h rdata=%h required all zero", ram_addr, ram_din, rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        int lat;
        set_req(0, 1'b0, 12'h000, 8'h00);
        wait_ack(0, lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL rd0_ack_lat got=%0d required=1", lat); end
        wait_rv(0, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL rd0_rv_lat got=%0d required=2", lat); end
        checks++;
        if (rdata !== sh_read(12'h000)) begin errors++; $display("FAIL rd0_data got=%h required=%h", rdata, sh_read(12'h000)); end
    endtask

    task automatic test_write_read();
        int lat;
        set_req(1, 1'b1, 12'hFFF, 8'h5A);
        wait_ack(1, lat);
        checks++;
        if (lat !== 1 || {ram_ce, ram_we, ram_addr, ram_din} !== {1'b1, 1'b1, 12'hFFF, 8'h5A}) begin
            errors++;
            $display("FAIL wr1_issue lat=%0d ce=%b we=%b addr=%h din=%h required lat=1 ce=1 we=1 addr=fff din=5a", lat, ram_ce, ram_we, ram_addr, ram_din);
        end
        sh_write(12'hFFF, 8'h5A);
        set_req(1, 1'b0, 12'hFFF, 8'h00);
        @(negedge clk);
        checks++;
        if ({ram_ce, ram_we, busy} !== 3'b000) begin
            errors++;
            $display("FAIL wr1_idle got ce/we/busy=%b required=000", {ram_ce, ram_we, busy});
        end
        wait_ack(1, lat);
        checks++;
        if (lat !== 1 || {ram_ce, ram_we} !== 2'b10) begin
            errors++;
            $display("FAIL rd1_issue lat=%0d ce/we=%b required lat=1 ce/we=10", lat, {ram_ce, ram_we});
        end
        wait_rv(1, lat);
        checks++;
        if (lat !== 2 || rdata !== 8'h5A || r0_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd1_data lat=%0d rdata=%h r0_rvalid=%b required lat=2 rdata=5a r0_rvalid=0", lat, rdata, r0_rvalid);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (rdata !== 8'h5A || r1_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rdata_hold rdata=%h rvalid=%b required rdata=5a rvalid=0", rdata, r1_rvalid);
        end
    endtask

    task automatic test_contention();
        int who_q[$];
        int cyc_q[$];
        apply_reset();
        set_req(0, 1'b0, 12'h010, 8'h00);
        set_req(1, 1'b0, 12'h020, 8'h00);
        for (int c = 1; c <= 40 && who_q.size() < 6; c++) begin
            @(negedge clk);
            if (r0_ack) begin who_q.push_back(0); cyc_q.push_back(c); end
            if (r1_ack) begin who_q.push_back(1); cyc_q.push_back(c); end
        end
        r0_req = 1'b0; r1_req = 1'b0;
        checks++;
        if (who_q.size() != 6) begin errors++; $display("FAIL cont_count got=%0d required=6", who_q.size()); end
        for (int k = 0; k < who_q.size(); k++) begin
            checks++;
            if (who_q[k] != (RR_EN ? (k % 2) : 0)) begin
                errors++;
                $display("FAIL cont_order idx=%0d got=r%0d required=r%0d", k, who_q[k], RR_EN ? (k % 2) : 0);
            end
            checks++;
            if (cyc_q[k] != 1 + 3 * k) begin
                errors++;
                $display("FAIL cont_cycle idx=%0d got=%0d required=%0d", k, cyc_q[k], 1 + 3 * k);
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_lock();
        int lat;
        logic [7:0] v;
        apply_reset();
        r0_lock = 1'b1;
        set_req(0, 1'b0, 12'h100, 8'h00);
        set_req(1, 1'b0, 12'h200, 8'h00);
        wait_ack(0, lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL lock_rd_ack got=%0d required=1", lat); end
        wait_rv(0, lat);
        checks++;
        if (lat !== 2 || rdata !== sh_read(12'h100)) begin
            errors++;
            $display("FAIL lock_rd_data lat=%0d rdata=%h required lat=2 rdata=%h", lat, rdata, sh_read(12'h100));
        end
        v = rdata + 8'h01;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (r1_ack !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL lock_hold r1_ack=%b busy=%b required 0 0", r1_ack, busy);
            end
        end
        set_req(0, 1'b1, 12'h100, v);
        wait_ack(0, lat);
        r0_lock = 1'b0;
        checks++;
        if (lat !== 1 || ram_we !== 1'b1 || ram_din !== v) begin
            errors++;
            $display("FAIL lock_wr lat=%0d we=%b din=%h required lat=1 we=1 din=%h", lat, ram_we, ram_din, v);
        end
        sh_write(12'h100, v);
        wait_ack(1, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL lock_release r1 ack lat=%0d required=2", lat); end
        wait_rv(1, lat);
        checks++;
        if (rdata !== sh_read(12'h200)) begin errors++; $display("FAIL lock_r1_data got=%h required=%h", rdata, sh_read(12'h200)); end
    endtask

    task automatic test_reset_mid();
        int lat;
        set_req(1, 1'b0, 12'h300, 8'h00);
        wait_ack(1, lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL rstmid_ack got=%0d required=1", lat); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_wait got=%b required=1", busy); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, ram_ce, r1_rvalid, r1_ack} !== 4'b0) begin
            errors++;
            $display("FAIL rstmid_async busy/ce/rvalid/ack=%b required=0000", {busy, ram_ce, r1_rvalid, r1_ack});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (r1_rvalid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_drop r1_rvalid=%b busy=%b required 0 0", r1_rvalid, busy);
            end
        end
        set_req(1, 1'b0, 12'h300, 8'h00);
        wait_ack(1, lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL rstmid_retry_ack got=%0d required=1", lat); end
        wait_rv(1, lat);
        checks++;
        if (lat !== 2 || rdata !== sh_read(12'h300)) begin
            errors++;
            $display("FAIL rstmid_retry_data lat=%0d rdata=%h required lat=2 rdata=%h", lat, rdata, sh_read(12'h300));
        end
    endtask

    task automatic test_random();
        bit          pend [2];
        bit          we_a [2];
        logic [11:0] ad [2];
        logic [7:0]  wd [2];
        bit          lk;
        int          last_g, idle_from, exp_who, exp_c, rv_who, rv_c, g, k;
        bit          e0, e1, v0, v1;
        logic [7:0]  rv_data;
        pend[0] = 1'b0; pend[1] = 1'b0; lk = 1'b0;
        last_g = 1; idle_from = 0; exp_who = -1; exp_c = -1; rv_who = -1; rv_c = -1; rv_data = 8'h00;
        apply_reset();
        for (int c = 0; c < 430; c++) begin
            e0 = (exp_c == c) && (exp_who == 0);
            e1 = (exp_c == c) && (exp_who == 1);
            v0 = (rv_c == c) && (rv_who == 0);
            v1 = (rv_c == c) && (rv_who == 1);
            checks++;
            if (r0_ack !== e0 || r1_ack !== e1) begin
                errors++;
                $display("FAIL rnd_ack cyc=%0d got=%b%b required=%b%b", c, r0_ack, r1_ack, e0, e1);
            end
            checks++;
            if (r0_rvalid !== v0 || r1_rvalid !== v1) begin
                errors++;
                $display("FAIL rnd_rvalid cyc=%0d got=%b%b required=%b%b", c, r0_rvalid, r1_rvalid, v0, v1);
            end
            if (v0 || v1) begin
                checks++;
                if (rdata !== rv_data) begin errors++; $display("FAIL rnd_rdata cyc=%0d got=%h required=%h", c, rdata, rv_data); end
            end
            if (e0 || e1) begin
                k = e1 ? 1 : 0;
                checks++;
                if (we_a[k] && {ram_we, ram_addr, ram_din} !== {1'b1, ad[k], wd[k]}) begin
                    errors++;
                    $display("FAIL rnd_wr cyc=%0d we=%b addr=%h din=%h required we=1 addr=%h din=%h", c, ram_we, ram_addr, ram_din, ad[k], wd[k]);
                end else if (!we_a[k] && {ram_we, ram_addr} !== {1'b0, ad[k]}) begin
                    errors++;
                    $display("FAIL rnd_rd cyc=%0d we=%b addr=%h required we=0 addr=%h", c, ram_we, ram_addr, ad[k]);
                end
                if (we_a[k]) begin
                    sh_write(ad[k], wd[k]);
                    idle_from = c + 1;
                end else begin
                    rv_who = k; rv_c = c + 2; rv_data = sh_read(ad[k]);
                    idle_from = c + 2;
                end
                last_g = k;
                pend[k] = 1'b0;
            end
            if (c < 400) begin
                for (int j = 0; j < 2; j++) begin
                    if (!pend[j] && $urandom_range(0, 2) != 0) begin
                        pend[j] = 1'b1;
                        we_a[j] = 1'($urandom_range(0, 1));
                        ad[j]   = {8'hA5, 4'($urandom_range(0, 15))};
                        wd[j]   = 8'($urandom);
                    end
                end
                if ($urandom_range(0, 9) == 0) lk = !lk;
            end else begin
                lk = 1'b0;
            end
            r0_req = pend[0]; r0_we = we_a[0]; r0_addr = ad[0]; r0_wdata = wd[0];
            r1_req = pend[1]; r1_we = we_a[1]; r1_addr = ad[1]; r1_wdata = wd[1];
            r0_lock = lk;
            if (c >= idle_from) begin
                g = -1;
                if (lk && last_g == 0) g = pend[0] ? 0 : -1;
                else if (pend[0] && pend[1]) g = RR_EN ? 1 - last_g : 0;
                else if (pend[0]) g = 0;
                else if (pend[1]) g = 1;
                if (g >= 0) begin
                    exp_who = g; exp_c = c + 1; idle_from = 1000000;
                end
            end
            @(negedge clk);
        end
        r0_req = 1'b0; r1_req = 1'b0; r0_lock = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_lock();
        test_reset_mid();
        test_random();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dpb_port_arbiter.md
DPB_PORT_ARBITER -- requirements
Module: dpb_port_arbiter

Interface
REQ-001 The block SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-002 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 The block SHALL have ports r0_req / r1_req, input, 1 each, access request; held high until ack.
REQ-004 The block SHALL have ports r0_we / r1_we, input, 1 each, 1=write, 0=read; stable while req high.
REQ-005 The block SHALL have ports r0_addr / r1_addr, input, 12 each, byte address; stable while req high.
REQ-006 The block SHALL have ports r0_wdata / r1_wdata, input, 8 each, write data; stable while req high.
REQ-007 The block SHALL have port r0_lock, input, 1, requester 0 bus lock for atomic read-modify-write.
REQ-008 The block SHALL have ports r0_ack / r1_ack, output, 1 each, one-cycle pulse when the access is issued to RAM.
REQ-009 The block SHALL have ports r0_rvalid / r1_rvalid, output, 1 each, one-cycle pulse when rdata holds read data.
REQ-010 The block SHALL have port rdata, output, 8, registered read data, shared by both requesters.
REQ-011 The block SHALL have ports ram_ce / ram_we, output, 1 each, RAM port-A clock enable and write enable.
REQ-012 The block SHALL have ports ram_addr / ram_din, output, 12 / 8, RAM port-A address and write data, registered.
REQ-013 The block SHALL have port ram_oce, output, 1, tied 1.
REQ-014 The block SHALL have port ram_dout, input, 8, RAM port-A read data; bypass read mode, valid the cycle after the RAM samples.
REQ-015 The block SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT.
REQ-017 IDLE: if any req is high, the FSM SHALL select a winner per REQ-022/023, register its we/addr/wdata into ram_we/ram_addr/ram_din, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-018 ISSUE: ram_ce SHALL be 1 and the winner's ack SHALL be 1 for exactly this cycle; on a write, next state SHALL be IDLE; on a read, next state SHALL be WAIT.
REQ-019 WAIT: ram_dout SHALL be captured into rdata at the cycle end, and the winner's rvalid SHALL pulse in the following cycle; next state SHALL be IDLE.
REQ-020 Latency: the read rvalid SHALL occur 2 cycles after ack; peak throughput SHALL be 1 write per 2 cycles and 1 read per 3 cycles.
REQ-021 ram_ce and ram_we SHALL be 0 in IDLE and WAIT; ram_we SHALL be 0 in ISSUE for reads.
REQ-022 Arbitration with a single req SHALL grant that requester.
REQ-023 Simultaneous requests SHALL be resolved per REQ-031/032.
REQ-024 Lock: if r0_lock is high in IDLE and the last grant was r0, only r0 SHALL be eligible and r1 SHALL wait regardless of priority; lock sampled low SHALL release at once.
REQ-025 A req deasserted before ack (protocol violation) SHALL NOT abort the access in flight; the access SHALL complete and the ack/rvalid SHALL still be issued.
REQ-026 rdata SHALL hold its value until the next read capture.
REQ-027 At most one ack and at most one rvalid SHALL be high in any cycle; an ack and an rvalid for different requesters SHALL NOT overlap, because IDLE always separates them.

Reset
REQ-028 On rst_n low, the state SHALL become IDLE asynchronously, and all acks, rvalids, ram_ce, ram_we and busy SHALL be 0.
REQ-029 On rst_n low, ram_addr, ram_din and rdata SHALL be 0, and the last-grant pointer SHALL be set to r1 so that r0 wins the first contention.
REQ-030 A reset mid-access SHALL drop the access with no ack or rvalid; if ram_ce was high, the RAM write in that cycle is not guaranteed.

Configuration
REQ-031 With macro DPB_ARB_RR_EN defined, contention SHALL go round-robin: the requester not granted last wins, and the pointer SHALL update on every ISSUE.
REQ-032 Without DPB_ARB_RR_EN, contention SHALL use fixed priority with r0 always winning, and the pointer SHALL be kept only for lock (REQ-024).

Verification
REQ-033 Reset, then r0 reads addr 0x000 alone -> ack at cycle 1, rvalid at cycle 3, and rdata equals the RAM init byte at 0x000.
REQ-034 r1 writes 0x5A to 0xFFF, then r1 reads 0xFFF -> ram_we=1 only in the first ISSUE, then rdata=0x5A with r1_rvalid pulse.
REQ-035 r0 and r1 request continuously with RR enabled -> acks alternate r0,r1,r0,r1; with RR disabled -> only r0 is acked while r0_req stays high.
REQ-036 r0_lock=1 with r0 read then write to 0x100, and r1 requesting throughout -> r1_ack only after lock drops; no r1 access occurs between r0's read and write.
REQ-037 rst_n pulsed low during WAIT of an r1 read -> no r1_rvalid, state IDLE, busy=0, then the next request is served normally.
